// File: rtl/washer_plant_model.sv
// Behavioural plant for the washing-machine controller. It turns actuator
// commands into the sensor and timer inputs the controller waits on, and
// closes the control loop in simulation and on bring-up boards.
//
// Ports:
//   clk            : system clock, all state updates on the rising edge
//   rst            : synchronous, active-low reset
//   doorlock       : door locked by the controller
//   fillvalve_on   : fill valve command
//   drainvalve_on  : drain valve command
//   motor_on       : drum motor command
//   soap_wash      : soap phase flag
//   water_wash     : rinse phase flag
//   done           : programme-complete pulse
//   filled         : water_level == FILL_LEVEL (decoded from the level register)
//   drained        : water_level == 0 (decoded from the level register)
//   detergent      : detergent dosed, held until done
//   cycletime_out  : one-cycle pulse at the end of each wash period
//   spintime_out   : one-cycle pulse at the end of the final spin
//   fault          : sticky interlock violation flag
//   water_level    : current tub level
module washer_plant_model #(
    parameter int unsigned FILL_LEVEL  = 8,
    parameter int unsigned DET_CYCLES  = 3,
    parameter int unsigned WASH_CYCLES = 16,
    parameter int unsigned SPIN_CYCLES = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       doorlock,
    input  logic       fillvalve_on,
    input  logic       drainvalve_on,
    input  logic       motor_on,
    input  logic       soap_wash,
    input  logic       water_wash,
    input  logic       done,
    output logic       filled,
    output logic       drained,
    output logic       detergent,
    output logic       cycletime_out,
    output logic       spintime_out,
    output logic       fault,
    output logic [7:0] water_level
);

    localparam int unsigned CNT_W = 8;

    // Every parameter must fit the 8-bit counters and be non-zero.
    if (FILL_LEVEL  < 1 || FILL_LEVEL  > 255 ||
        DET_CYCLES  < 1 || DET_CYCLES  > 255 ||
        WASH_CYCLES < 1 || WASH_CYCLES > 255 ||
        SPIN_CYCLES < 1 || SPIN_CYCLES > 255) begin : g_param_check
        $error("washer_plant_model: parameters must lie in 1..255");
    end

    localparam logic [CNT_W-1:0] L_FILL      = CNT_W'(FILL_LEVEL);
    localparam logic [CNT_W-1:0] L_DET_LAST  = CNT_W'(DET_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_WASH_LAST = CNT_W'(WASH_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_SPIN_LAST = CNT_W'(SPIN_CYCLES - 1);

    logic [CNT_W-1:0] r_level;
    logic [CNT_W-1:0] r_dose_cnt;
    logic [CNT_W-1:0] r_wash_cnt;
    logic [CNT_W-1:0] r_spin_cnt;
    logic             r_detergent;
    logic             r_cycletime;
    logic             r_spintime;
    logic             r_fault;

    logic w_filled;
    logic w_drained;
    logic w_fill_only;
    logic w_drain_only;
    logic w_dose_run;
    logic w_wash_run;
    logic w_spin_run;
    logic w_interlock_bad;

    // Level decodes and run conditions.
    assign w_filled        = (r_level == L_FILL);
    assign w_drained       = (r_level == '0);
    assign w_fill_only     = fillvalve_on & ~drainvalve_on;
    assign w_drain_only    = drainvalve_on & ~fillvalve_on;
    assign w_dose_run      = soap_wash & w_filled & ~r_detergent;
    assign w_wash_run      = motor_on & w_filled & doorlock;
    assign w_spin_run      = water_wash & w_drained & drainvalve_on & doorlock;
    assign w_interlock_bad = (fillvalve_on & drainvalve_on) |
                             (motor_on & ~doorlock) |
                             (fillvalve_on & ~doorlock);

    // Tub level: saturating up/down; both valves open holds the level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_level <= '0;
        end else if (w_fill_only && (r_level != L_FILL)) begin
            r_level <= r_level + CNT_W'(1);
        end else if (w_drain_only && (r_level != '0)) begin
            r_level <= r_level - CNT_W'(1);
        end
    end

    // Detergent doser; done takes priority over a completing dose.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dose_cnt  <= '0;
            r_detergent <= 1'b0;
        end else begin
            if (w_dose_run && (r_dose_cnt != L_DET_LAST)) begin
                r_dose_cnt <= r_dose_cnt + CNT_W'(1);
            end else begin
                r_dose_cnt <= '0;
            end

            if (done) begin
                r_detergent <= 1'b0;
            end else if (w_dose_run && (r_dose_cnt == L_DET_LAST)) begin
                r_detergent <= 1'b1;
            end
        end
    end

    // Wash period timer; any break in the run condition restarts it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wash_cnt  <= '0;
            r_cycletime <= 1'b0;
        end else if (w_wash_run) begin
            if (r_wash_cnt == L_WASH_LAST) begin
                r_wash_cnt  <= '0;
                r_cycletime <= 1'b1;
            end else begin
                r_wash_cnt  <= r_wash_cnt + CNT_W'(1);
                r_cycletime <= 1'b0;
            end
        end else begin
            r_wash_cnt  <= '0;
            r_cycletime <= 1'b0;
        end
    end

    // Final spin timer, same restart behaviour as the wash timer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_spin_cnt <= '0;
            r_spintime <= 1'b0;
        end else if (w_spin_run) begin
            if (r_spin_cnt == L_SPIN_LAST) begin
                r_spin_cnt <= '0;
                r_spintime <= 1'b1;
            end else begin
                r_spin_cnt <= r_spin_cnt + CNT_W'(1);
                r_spintime <= 1'b0;
            end
        end else begin
            r_spin_cnt <= '0;
            r_spintime <= 1'b0;
        end
    end

    // Sticky interlock fault; it only reports and never gates the counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fault <= 1'b0;
        end else if (w_interlock_bad) begin
            r_fault <= 1'b1;
        end
    end

    assign filled        = w_filled;
    assign drained       = w_drained;
    assign detergent     = r_detergent;
    assign cycletime_out = r_cycletime;
    assign spintime_out  = r_spintime;
    assign fault         = r_fault;
    assign water_level   = r_level;

endmodule

// File: tb/tb_washer_plant_model.sv
// Scoreboard bench for washer_plant_model: each stimulus cycle queues the
// output values expected after the next rising edge; they are popped and
// compared 1 ns after that edge.
module tb_washer_plant_model;

    localparam int unsigned SIG_LEVEL = 0;
    localparam int unsigned SIG_FILL  = 1;
    localparam int unsigned SIG_DRAIN = 2;
    localparam int unsigned SIG_DET   = 3;
    localparam int unsigned SIG_CYC   = 4;
    localparam int unsigned SIG_SPIN  = 5;
    localparam int unsigned SIG_FAULT = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       doorlock;
    logic       fillvalve_on;
    logic       drainvalve_on;
    logic       motor_on;
    logic       soap_wash;
    logic       water_wash;
    logic       done;
    logic       filled;
    logic       drained;
    logic       detergent;
    logic       cycletime_out;
    logic       spintime_out;
    logic       fault;
    logic [7:0] water_level;

    int n_checks = 0;
    int n_fail   = 0;

    string       q_tag[$];
    int unsigned q_id[$];
    logic [7:0]  q_exp[$];

    washer_plant_model dut (
        .clk           (clk),
        .rst           (rst),
        .doorlock      (doorlock),
        .fillvalve_on  (fillvalve_on),
        .drainvalve_on (drainvalve_on),
        .motor_on      (motor_on),
        .soap_wash     (soap_wash),
        .water_wash    (water_wash),
        .done          (done),
        .filled        (filled),
        .drained       (drained),
        .detergent     (detergent),
        .cycletime_out (cycletime_out),
        .spintime_out  (spintime_out),
        .fault         (fault),
        .water_level   (water_level)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] obs_sig(input int unsigned id);
        case (id)
            SIG_LEVEL: obs_sig = water_level;
            SIG_FILL:  obs_sig = {7'd0, filled};
            SIG_DRAIN: obs_sig = {7'd0, drained};
            SIG_DET:   obs_sig = {7'd0, detergent};
            SIG_CYC:   obs_sig = {7'd0, cycletime_out};
            SIG_SPIN:  obs_sig = {7'd0, spintime_out};
            default:   obs_sig = {7'd0, fault};
        endcase
    endfunction

    task automatic push_exp(input string tag, input int unsigned id, input logic [7:0] v);
        q_tag.push_back(tag);
        q_id.push_back(id);
        q_exp.push_back(v);
    endtask

    // Clock one edge, then drain the scoreboard against the DUT outputs.
    task automatic step();
        string       t;
        int unsigned id;
        logic [7:0]  e;
        @(posedge clk);
        #1;
        while (q_id.size() > 0) begin
            t  = q_tag.pop_front();
            id = q_id.pop_front();
            e  = q_exp.pop_front();
            check(t, obs_sig(id), e);
        end
    endtask

    task automatic push_idle_state(input string tag);
        push_exp({tag, "_level"}, SIG_LEVEL, 8'd0);
        push_exp({tag, "_drained"}, SIG_DRAIN, 8'd1);
        push_exp({tag, "_filled"}, SIG_FILL, 8'd0);
        push_exp({tag, "_det"}, SIG_DET, 8'd0);
        push_exp({tag, "_cyc"}, SIG_CYC, 8'd0);
        push_exp({tag, "_spin"}, SIG_SPIN, 8'd0);
        push_exp({tag, "_fault"}, SIG_FAULT, 8'd0);
    endtask

    task automatic fill_to_full(input string tag);
        fillvalve_on  = 1'b1;
        drainvalve_on = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            push_exp($sformatf("%s_lvl%0d", tag, i), SIG_LEVEL, 8'(i));
            step();
        end
        fillvalve_on = 1'b0;
    endtask

    initial begin
        rst = 1'b0; doorlock = 1'b0; fillvalve_on = 1'b0; drainvalve_on = 1'b0;
        motor_on = 1'b0; soap_wash = 1'b0; water_wash = 1'b0; done = 1'b0;

        // Reset held two cycles, then released with idle inputs.
        step();
        push_idle_state("rst");
        step();
        rst = 1'b1;
        push_idle_state("rst_rel");
        step();

        // Fill with saturation, then drain with saturation.
        doorlock = 1'b1;
        fillvalve_on = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            push_exp($sformatf("fill_lvl%0d", i), SIG_LEVEL, 8'((i > 8) ? 8 : i));
            push_exp($sformatf("fill_full%0d", i), SIG_FILL, 8'((i >= 8) ? 1 : 0));
            push_exp($sformatf("fill_drn%0d", i), SIG_DRAIN, 8'd0);
            step();
        end
        fillvalve_on  = 1'b0;
        drainvalve_on = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            push_exp($sformatf("drain_lvl%0d", i), SIG_LEVEL, 8'((i > 8) ? 0 : 8 - i));
            push_exp($sformatf("drain_drn%0d", i), SIG_DRAIN, 8'((i >= 8) ? 1 : 0));
            push_exp($sformatf("drain_full%0d", i), SIG_FILL, 8'd0);
            step();
        end
        drainvalve_on = 1'b0;
        push_exp("filldrain_fault", SIG_FAULT, 8'd0);
        step();

        // Wash timer: pulses at 16 and 32, then restart after a dropout.
        fill_to_full("wash");
        motor_on = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            push_exp($sformatf("wash_cyc%0d", i), SIG_CYC, 8'((i == 16 || i == 32) ? 1 : 0));
            step();
        end
        for (int i = 1; i <= 10; i++) begin
            push_exp($sformatf("wash_pre%0d", i), SIG_CYC, 8'd0);
            step();
        end
        motor_on = 1'b0;
        push_exp("wash_drop", SIG_CYC, 8'd0);
        step();
        motor_on = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            push_exp($sformatf("wash_re%0d", i), SIG_CYC, 8'((i == 16) ? 1 : 0));
            step();
        end
        motor_on = 1'b0;
        push_exp("wash_level", SIG_LEVEL, 8'd8);
        step();

        // Dosing, clear by done, and done coincident with dose completion.
        soap_wash = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            push_exp($sformatf("dose%0d", i), SIG_DET, 8'((i >= 3) ? 1 : 0));
            step();
        end
        done = 1'b1;
        push_exp("dose_done", SIG_DET, 8'd0);
        step();
        done = 1'b0;
        soap_wash = 1'b0;
        push_exp("dose_idle", SIG_DET, 8'd0);
        step();
        soap_wash = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            done = (i == 3) ? 1'b1 : 1'b0;
            push_exp($sformatf("dose_race%0d", i), SIG_DET, 8'((i == 6) ? 1 : 0));
            step();
        end
        done = 1'b1;
        soap_wash = 1'b0;
        push_exp("dose_clr", SIG_DET, 8'd0);
        step();
        done = 1'b0;

        // Drain, then final spin.
        drainvalve_on = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            push_exp($sformatf("spin_drain%0d", i), SIG_LEVEL, 8'(8 - i));
            step();
        end
        water_wash = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            push_exp($sformatf("spin%0d", i), SIG_SPIN, 8'((i == 12) ? 1 : 0));
            step();
        end
        water_wash = 1'b0;
        drainvalve_on = 1'b0;
        push_exp("spin_fault", SIG_FAULT, 8'd0);
        step();

        // Both valves open: level holds, fault latches and sticks.
        fillvalve_on = 1'b1;
        drainvalve_on = 1'b1;
        push_exp("both_level", SIG_LEVEL, 8'd0);
        push_exp("both_fault", SIG_FAULT, 8'd1);
        step();
        fillvalve_on = 1'b0;
        drainvalve_on = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            push_exp($sformatf("both_sticky%0d", i), SIG_FAULT, 8'd1);
            step();
        end
        rst = 1'b0;
        push_exp("both_rst", SIG_FAULT, 8'd0);
        step();
        rst = 1'b1;

        // Motor with door unlocked.
        doorlock = 1'b0;
        motor_on = 1'b1;
        push_exp("motor_unlocked", SIG_FAULT, 8'd1);
        step();
        motor_on = 1'b0;
        doorlock = 1'b1;
        rst = 1'b0;
        push_exp("motor_rst", SIG_FAULT, 8'd0);
        step();
        rst = 1'b1;

        // Reset mid-wash, then a full-length wash period.
        fill_to_full("mid");
        motor_on = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            push_exp($sformatf("mid_cyc%0d", i), SIG_CYC, 8'd0);
            step();
        end
        rst = 1'b0;
        push_idle_state("mid_rst");
        step();
        rst = 1'b1;
        fill_to_full("mid_refill");
        for (int i = 1; i <= 16; i++) begin
            push_exp($sformatf("mid_wash%0d", i), SIG_CYC, 8'((i == 16) ? 1 : 0));
            step();
        end
        motor_on = 1'b0;
        push_exp("mid_fault", SIG_FAULT, 8'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/washer_plant_model.md
Name: washer_plant_model

Overview:
- Behavioural responder for the washing-machine controller FSM; closes the control loop in simulation and on FPGA bring-up boards.
- Consumes the controller's actuator commands: door lock, fill valve, drain valve, motor, soap/water wash phase flags and done.
- Produces the sensor and timer inputs the controller waits on: filled, drained, detergent, cycletime_out and spintime_out.
- Uses saturating level and timer counters, plus a sticky interlock fault flag.

Parameters:
FILL_LEVEL, 8, water_level value at which the tub is full (1..255)
DET_CYCLES, 3, cycles of dosing at full level before detergent asserts (1..255)
WASH_CYCLES, 16, motor cycles at full level per wash/rinse period (1..255)
SPIN_CYCLES, 12, cycles of final spin before spintime_out (1..255)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-low
doorlock  input  1  door locked by controller
fillvalve_on  input  1  fill valve command
drainvalve_on  input  1  drain valve command
motor_on  input  1  drum motor command
soap_wash  input  1  soap phase flag from controller
water_wash  input  1  rinse phase flag from controller
done  input  1  programme-complete pulse from controller
filled  output  1  water_level == FILL_LEVEL
drained  output  1  water_level == 0
detergent  output  1  detergent dosed
cycletime_out  output  1  one-cycle pulse at end of a wash period
spintime_out  output  1  one-cycle pulse at end of spin
fault  output  1  sticky interlock violation flag
water_level  output  8  current tub level

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst). When rst==0 at a rising edge, all state clears. It takes effect mid-operation too, with no partial completion.
- Reset values:
  - water_level=0, so drained=1 and filled=0.
  - detergent=0, cycletime_out=0, spintime_out=0, fault=0.
  - All internal counters are 0.
- filled and drained are combinational decodes of the registered water_level. All other outputs are registered.
- Level counter, evaluated each cycle:
  - fillvalve_on & !drainvalve_on: increment, saturating at FILL_LEVEL.
  - drainvalve_on & !fillvalve_on: decrement, saturating at 0.
  - Both asserted: hold level and set fault.
  - Neither asserted: hold.
- Detergent doser:
  - dose_cnt increments while soap_wash & filled & !detergent.
  - When dose_cnt == DET_CYCLES-1 at an edge, detergent<=1 on that edge and dose_cnt clears.
  - If the condition drops mid-dose, dose_cnt clears.
  - detergent holds at 1 until done==1 or reset; done clears it on the next edge.
- Wash timer:
  - wash_cnt increments while motor_on & filled & doorlock.
  - At wash_cnt == WASH_CYCLES-1: cycletime_out<=1 for exactly one cycle and wash_cnt clears.
  - If the condition drops, wash_cnt clears (no pause/resume).
  - cycletime_out is 0 in every cycle it is not pulsing.
  - Latency: first qualifying cycle to pulse is WASH_CYCLES edges.
- Spin timer:
  - spin_cnt increments while water_wash & drained & drainvalve_on & doorlock.
  - At spin_cnt == SPIN_CYCLES-1: spintime_out pulses one cycle and spin_cnt clears.
  - If the condition drops, spin_cnt clears.
- Fault (sticky, cleared only by reset). Set on the edge following any of:
  - fillvalve_on & drainvalve_on;
  - motor_on & !doorlock;
  - fillvalve_on & !doorlock.
- Fault is observational only: counters continue to follow the rules above.
- Simultaneous done and dose completion in the same cycle: done wins, detergent stays 0.
- Parameters of 0 or above 255 are unsupported; the generate check fails at elaboration.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release -> water_level=0, drained=1, filled=0, detergent=0, fault=0, no pulses.
- Fill/drain:
  - doorlock=1, fillvalve_on=1 for 10 cycles -> water_level steps 1..8, then saturates; filled=1 from cycle 8.
  - Then drainvalve_on=1 only -> level falls to 0 after 8 cycles; drained=1.
- Wash:
  - At full level with motor_on=1, doorlock=1 -> cycletime_out high exactly at cycle 16, then at 32.
  - Dropping motor_on at cycle 10, then re-asserting it -> pulse 16 cycles after re-assertion.
- Dose: soap_wash=1 at full level -> detergent=1 after 3 cycles. done pulse -> detergent=0 next cycle. done coincident with the 3rd dosing cycle -> detergent stays 0.
- Spin: water_wash=1, drainvalve_on=1, level 0, doorlock=1 -> spintime_out one-cycle pulse at cycle 12.
- Faults:
  - fillvalve_on=drainvalve_on=1 -> level holds, fault=1 next cycle and stays 1 after both are released.
  - motor_on=1 with doorlock=0 -> fault=1.
  - Synchronous reset mid-wash (cnt=7) -> all clear, and the next wash takes a full 16 cycles.
